adder_sweep_checker: RTL and testbench
======================================

# adder_sweep_checker

Sequential stimulus/checker that drives the operand side of the 4-bit ripple adder (`a`, `b`, `c_in`) and consumes its result side (`s`, `c_out`). On `start` it sweeps all 512 operand combinations and compares each result against an internally computed sum. It reports pass/fail, an error count and the first failing vector. It sits on the FPGA next to the adder so the adder can be checked in hardware without a simulator.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles operands are held before the result is sampled. Legal range is 1..15.
- `ERR_W`, default 10: width of the error counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a sweep. Honoured only in IDLE or DONE.
- `a`  out  4  operand A to the adder (registered).
- `b`  out  4  operand B to the adder (registered).
- `c_in`  out  1  carry-in to the adder (registered).
- `s`  in  4  adder sum.
- `c_out`  in  1  adder carry-out.
- `busy`  out  1  high while a sweep is running.
- `done`  out  1  high in DONE; held until the next `start` or reset.
- `pass`  out  1  `done && err_count == 0`.
- `err_count`  out  ERR_W  number of mismatching vectors, saturating.
- `fail_seen`  out  1  at least one mismatch in the current sweep.
- `fail_vec`  out  9  first failing vector as `{c_in, a, b}`.

## Operation
- The vector index `idx` is 9 bits. The operand mapping is `c_in = idx[8]`, `a = idx[7:4]`, `b = idx[3:0]`, so `b` varies fastest.
- Expected value is the 5-bit result `{1'b0,a} + {1'b0,b} + c_in`. This is compared against `{c_out, s}`. Any bit difference counts as a mismatch.
- FSM states are IDLE, SETTLE, CHECK and DONE.
  - **IDLE / DONE, on `start`:** `idx` ← 0, `err_count` ← 0, `fail_seen` ← 0, `fail_vec` ← 0, `done` ← 0, settle counter ← `SETTLE_CYCLES - 1`, next state SETTLE.
  - **SETTLE:** the counter decrements each cycle. At 0, go to CHECK.
  - **CHECK:** sample and compare.
    - On a mismatch, increment `err_count`, saturating at 2^ERR_W − 1.
    - If `fail_seen` is 0 on a mismatch, latch `fail_vec` ← `idx` and set `fail_seen` ← 1.
    - If `idx == 511`, go to DONE.
    - Otherwise, increment `idx`, reload the counter, and go to SETTLE.
- `busy` is high in SETTLE and CHECK.
- `start` is ignored while `busy`.
- Operand outputs always reflect `idx`. In IDLE they are 0. In DONE they hold the last vector.

## Timing
- Reset values: `a`, `b`, `c_in`, `busy`, `done`, `pass`, `err_count`, `fail_seen` and `fail_vec` are all 0. State is IDLE.
- `rst_n` low at any time, including mid-sweep, forces the reset values immediately. No partial results survive.
- When `start` is sampled at edge k, vector 0 appears on `a`/`b`/`c_in` right after edge k, and `busy` rises at the same edge.
- Each vector takes `SETTLE_CYCLES + 1` cycles: `SETTLE_CYCLES` in SETTLE, then 1 in CHECK. The result is sampled at the CHECK-ending edge.
- `done` rises exactly 512 × (`SETTLE_CYCLES` + 1) cycles after edge k. `busy` falls at the same edge.
- `err_count`, `fail_seen` and `fail_vec` update at the CHECK-ending edge of the failing vector.
- A `start` arriving in DONE clears the results and restarts at that edge.

## Configuration
- Macro: `ADDER_CHK_STOP_ON_FAIL_EN`.
- **Defined:** on the first mismatch in CHECK, go directly to DONE. `err_count` is then 1, and the operands hold the failing vector.
- **Undefined:** the sweep always covers all 512 vectors, and `err_count` is the total mismatch count.

## Test plan
All scenarios use `SETTLE_CYCLES` = 2 and the macro undefined unless stated otherwise.
- **Correct adder:** `start` → `done` exactly 1536 cycles later; `pass` = 1, `err_count` = 0, `fail_seen` = 0.
- **`c_out` stuck at 0:** `err_count` = 256, `fail_vec` = 9'h01F (c_in=0, a=1, b=15), `pass` = 0.
- **`s[0]` stuck at 1, `ERR_W` = 4:** `err_count` saturates at 15, `fail_vec` = 9'h000.
- **`ADDER_CHK_STOP_ON_FAIL_EN` defined, `c_out` stuck at 0:** `done` 96 cycles after `start`; `err_count` = 1, operands hold a=1, b=15, c_in=0.
- **Reset mid-sweep:** drop `rst_n` 100 cycles after `start` → all outputs 0 at once. A new `start` then gives a clean pass after 1536 cycles.
- **`start` while busy:** pulse `start` at cycle 50 of a sweep → ignored; `done` still arrives at 1536 cycles and `err_count` is not reset.

Source files
------------

// File: rtl/adder_sweep_checker.sv
// Exhaustive in-hardware checker for a 4-bit ripple adder: sweeps all 512 {c_in,a,b}
// vectors and compares {c_out,s} to a reference sum. Optional: ADDER_CHK_STOP_ON_FAIL_EN.
module adder_sweep_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       a,
  output logic [3:0]       b,
  output logic             c_in,
  input  logic [3:0]       s,
  input  logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_seen,
  output logic [8:0]       fail_vec
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE     = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [8:0]       IDX_LAST    = 9'd511;

  // Reference 5-bit result for a vector laid out as {c_in, a, b}
  function automatic logic [4:0] expected_sum(input logic [8:0] vec);
    expected_sum = {1'b0, vec[7:4]} + {1'b0, vec[3:0]} + {4'b0000, vec[8]};
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    if (val == ERR_MAX) begin
      sat_inc = ERR_MAX;
    end else begin
      sat_inc = val + ERR_ONE;
    end
  endfunction

  logic [1:0]       state_r, state_s;
  logic [8:0]       idx_r, idx_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             fseen_r, fseen_s;
  logic [8:0]       fvec_r, fvec_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic             busy_r, busy_s;
  logic             mismatch_s;
  logic             stop_s;

  // Compare the adder result against the reference for the vector on the operands
  always_comb begin
    mismatch_s = ({c_out, s} != expected_sum(idx_r));
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
    stop_s = mismatch_s;
`else
    stop_s = 1'b0;
`endif
  end

  // Sweep sequencing and result bookkeeping
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    err_s   = err_r;
    fseen_s = fseen_r;
    fvec_s  = fvec_r;
    done_s  = done_r;
    pass_s  = pass_r;
    busy_s  = busy_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          idx_s   = 9'd0;
          err_s   = {ERR_W{1'b0}};
          fseen_s = 1'b0;
          fvec_s  = 9'd0;
          done_s  = 1'b0;
          pass_s  = 1'b0;
          busy_s  = 1'b1;
          cnt_s   = SETTLE_LOAD;
          state_s = ST_SETTLE;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == 4'd0) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      ST_CHECK: begin
        if (mismatch_s) begin
          err_s = sat_inc(err_r);
          if (!fseen_r) begin
            fseen_s = 1'b1;
            fvec_s  = idx_r;
          end else begin
            fvec_s  = fvec_r;
          end
        end else begin
          err_s = err_r;
        end
        // Operands stay on the last (or failing) vector once the sweep ends
        if ((idx_r == IDX_LAST) || stop_s) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          pass_s  = (err_s == {ERR_W{1'b0}});
        end else begin
          idx_s   = idx_r + 9'd1;
          cnt_s   = SETTLE_LOAD;
          state_s = ST_SETTLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = 9'd0;
        cnt_s   = 4'd0;
        done_s  = 1'b0;
        pass_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 9'd0;
      cnt_r   <= 4'd0;
      err_r   <= {ERR_W{1'b0}};
      fseen_r <= 1'b0;
      fvec_r  <= 9'd0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
      err_r   <= err_s;
      fseen_r <= fseen_s;
      fvec_r  <= fvec_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
      busy_r  <= busy_s;
    end
  end

  assign c_in      = idx_r[8];
  assign a         = idx_r[7:4];
  assign b         = idx_r[3:0];
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;
  assign fail_seen = fseen_r;
  assign fail_vec  = fvec_r;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Self-checking bench for adder_sweep_checker with a fault-injectable adder model and a
// scoreboard of per-sweep expectations.
module tb_adder_sweep_checker;

  typedef struct {
    int         cycles;
    int         err;
    logic       fseen;
    logic [8:0] fvec;
    logic       pass;
    logic [8:0] last_vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] fault = 2'd0;

  logic [3:0] a, b, s;
  logic       c_in, c_out, busy, done, pass, fail_seen;
  logic [9:0] err_count;
  logic [8:0] fail_vec;

  logic [3:0] a2, b2, s2;
  logic       c_in2, c_out2, busy2, done2, pass2, fail_seen2;
  logic [3:0] err_count2;
  logic [8:0] fail_vec2;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Adder model; flt 1 = c_out stuck at 0, flt 2 = s[0] stuck at 1
  function automatic logic [4:0] adder_model(input logic [8:0] v, input logic [1:0] flt);
    logic [4:0] r;
    r = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
    if (flt == 2'd1) r[4] = 1'b0;
    else if (flt == 2'd2) r[0] = 1'b1;
    return r;
  endfunction

  assign {c_out, s}   = adder_model({c_in, a, b}, fault);
  assign {c_out2, s2} = adder_model({c_in2, a2, b2}, 2'd2);

  adder_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in), .s(s),
    .c_out(c_out), .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_seen(fail_seen), .fail_vec(fail_vec));

  adder_sweep_checker #(.SETTLE_CYCLES(2), .ERR_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a2), .b(b2), .c_in(c_in2), .s(s2),
    .c_out(c_out2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2),
    .fail_seen(fail_seen2), .fail_vec(fail_vec2));

  function automatic exp_t predict(input logic [1:0] flt);
    exp_t       e;
    logic [4:0] good;
    logic [8:0] v;
    e.cycles = 512 * 3; e.err = 0; e.fseen = 1'b0; e.fvec = 9'd0; e.last_vec = 9'h1FF;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      good = 5'(v[7:4]) + 5'(v[3:0]) + 5'(v[8]);
      if (adder_model(v, flt) !== good) begin
        e.err++;
        if (!e.fseen) begin
          e.fseen = 1'b1;
          e.fvec = v;
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
          e.cycles = (i + 1) * 3;
          e.last_vec = v;
          break;
`endif
        end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_a"}, 32'(a), 32'd0);
    chk({tag, "_b"}, 32'(b), 32'd0);
    chk({tag, "_cin"}, 32'(c_in), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_fseen"}, 32'(fail_seen), 32'd0);
    chk({tag, "_fvec"}, 32'(fail_vec), 32'd0);
  endtask

  // mode 0: plain sweep, 1: extra start at cycle 50, 2: reset at cycle 100
  task automatic run_sweep(input logic [1:0] flt, input int mode);
    int   n;
    exp_t e;
    fault = flt;
    sb_q.push_back(predict(flt));
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("start_vec0", 32'({c_in, a, b}), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) chk("vec1", 32'({c_in, a, b}), 32'd1);
      if (mode == 1 && n == 50) start = 1'b1;
      if (mode == 1 && n == 51) start = 1'b0;
      if (mode == 2 && n == 100) begin
        #2 rst_n = 1'b0;
        #1 chk_zero_outputs("midrst");
        e = sb_q.pop_front();
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
    end
    e = sb_q.pop_front();
    chk("cycles", 32'(n), 32'(e.cycles));
    chk("err_count", 32'(err_count), 32'(e.err));
    chk("fail_seen", 32'(fail_seen), 32'(e.fseen));
    chk("fail_vec", 32'(fail_vec), 32'(e.fvec));
    chk("pass", 32'(pass), 32'(e.pass));
    chk("hold_vec", 32'({c_in, a, b}), 32'(e.last_vec));
    chk("busy_low", 32'(busy), 32'd0);
  endtask

  initial begin
    exp_t e2;
    #12;
    chk_zero_outputs("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_zero_outputs("idle");

    run_sweep(2'd0, 0);
    e2 = predict(2'd2);
    chk("sat_done", 32'(done2), 32'd1);
    chk("sat_err", 32'(err_count2), (e2.err > 15) ? 32'd15 : 32'(e2.err));
    chk("sat_fvec", 32'(fail_vec2), 32'(e2.fvec));
    chk("sat_pass", 32'(pass2), 32'd0);

    run_sweep(2'd1, 0);
    run_sweep(2'd0, 1);
    run_sweep(2'd0, 2);
    chk("rst_sat_busy", 32'(busy2), 32'd0);
    run_sweep(2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
